clk_period_meter: RTL

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

---
 rtl/clk_period_meter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/clk_period_meter.sv
// Measures the half-period of a slow, asynchronous clk_in in clk cycles and
// tracks lock against an expected half-period, with a no-edge timeout.
module clk_period_meter #(
    parameter int WIDTH    = 17,
    parameter int N_EXP    = 5000,
    parameter int TOL      = 4,
    parameter int LOCK_CNT = 4,
    parameter int TMO      = 20000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic [WIDTH-1:0] half_period,
    output logic             meas_valid,
    output logic             good,
    output logic             locked,
    output logic             timeout
);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int LO = (N_EXP > TOL) ? N_EXP - TOL : 0;
    localparam int HI = N_EXP + TOL;
    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] CNT_TMO   = WIDTH'(TMO - 1);
    localparam logic [GW-1:0]    GOOD_FULL = GW'(LOCK_CNT);

    typedef enum logic [1:0] {
        SEEK,
        MEASURE,
        LOCKED
    } state_t;

    state_t           state, state_next;
    logic             s1, s2, s3;
    logic [WIDTH-1:0] cnt;
    logic [GW-1:0]    good_cnt, good_cnt_next;
    logic             edge_det, measuring, tmo_hit, meas_ok;
    logic [WIDTH:0]   h_p0;

    // One bit wider than the counter so cnt+1 and the window bounds never wrap.
    function automatic logic in_tol(input logic [WIDTH:0] h);
        return (h >= (WIDTH+1)'(LO)) && (h <= (WIDTH+1)'(HI));
    endfunction

    always_comb begin
        edge_det      = s2 ^ s3;
        measuring     = (state != SEEK);
        h_p0          = {1'b0, cnt} + (WIDTH+1)'(1);
        meas_ok       = in_tol(h_p0);
        tmo_hit       = measuring && !edge_det && (cnt == CNT_TMO);
        good_cnt_next = good_cnt;
        state_next    = state;

        if (edge_det && measuring) begin
            if (!meas_ok)
                good_cnt_next = '0;
            else if (good_cnt != GOOD_FULL)
                good_cnt_next = good_cnt + GW'(1);
        end else if (tmo_hit) begin
            good_cnt_next = '0;
        end

        case (state)
            SEEK: begin
                if (edge_det)
                    state_next = MEASURE;
            end
            MEASURE, LOCKED: begin
                // An edge on the threshold cycle wins over the timeout.
                if (edge_det)
                    state_next = (good_cnt_next == GOOD_FULL) ? LOCKED : MEASURE;
                else if (tmo_hit)
                    state_next = SEEK;
            end
            default: state_next = SEEK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= SEEK;
        else
            state <= state_next;
    end

    // Stage p0: synchronizer, free-running counter, registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            cnt         <= '0;
            good_cnt    <= '0;
            half_period <= '0;
            meas_valid  <= 1'b0;
            good        <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            s1       <= clk_in;
            s2       <= s1;
            s3       <= s2;
            good_cnt <= good_cnt_next;

            if (edge_det)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + WIDTH'(1);

            meas_valid <= edge_det && measuring;
            if (edge_det && measuring) begin
                half_period <= h_p0[WIDTH-1:0];
                good        <= meas_ok;
            end

            locked <= (state_next == LOCKED);

            if (edge_det)
                timeout <= 1'b0;
            else if (tmo_hit)
                timeout <= 1'b1;
        end
    end
endmodule
